data_ram_arbiter: RTL

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

---
 rtl/data_ram_arbiter_if.sv | 47 ++++
 rtl/data_ram_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the two Data_RAM requesters, the arbiter and the RAM.
// The arbiter takes the slave view; the requesters/RAM side takes the master view.
interface data_ram_arbiter_if;
    logic        iM0_Req;
    logic        iM0_We;
    logic [2:0]  iM0_Funct3;
    logic [31:0] iM0_Addr;
    logic [31:0] iM0_WrData;
    logic        oM0_Gnt;
    logic        oM0_Rsp;
    logic        oM0_Err;
    logic [31:0] oM0_RdData;

    logic        iM1_Req;
    logic        iM1_We;
    logic [2:0]  iM1_Funct3;
    logic [31:0] iM1_Addr;
    logic [31:0] iM1_WrData;
    logic        oM1_Gnt;
    logic        oM1_Rsp;
    logic        oM1_Err;
    logic [31:0] oM1_RdData;

    logic        oRam_WrEn;
    logic [2:0]  oRam_Funct3;
    logic [31:0] oRam_Addr;
    logic [31:0] oRam_WrData;
    logic [31:0] iRam_RdData;

    modport slave (
        input  iM0_Req, iM0_We, iM0_Funct3, iM0_Addr, iM0_WrData,
        output oM0_Gnt, oM0_Rsp, oM0_Err, oM0_RdData,
        input  iM1_Req, iM1_We, iM1_Funct3, iM1_Addr, iM1_WrData,
        output oM1_Gnt, oM1_Rsp, oM1_Err, oM1_RdData,
        output oRam_WrEn, oRam_Funct3, oRam_Addr, oRam_WrData,
        input  iRam_RdData
    );

    modport master (
        output iM0_Req, iM0_We, iM0_Funct3, iM0_Addr, iM0_WrData,
        input  oM0_Gnt, oM0_Rsp, oM0_Err, oM0_RdData,
        output iM1_Req, iM1_We, iM1_Funct3, iM1_Addr, iM1_WrData,
        input  oM1_Gnt, oM1_Rsp, oM1_Err, oM1_RdData,
        input  oRam_WrEn, oRam_Funct3, oRam_Addr, oRam_WrData,
        output iRam_RdData
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port Data_RAM.
// Grant at T, RAM access from stage 1 at T+1, response pulse at T+2.
module data_ram_arbiter #(
    parameter int unsigned DEPTH_WORDS = 32
) (
    input logic                iClk,
    input logic                iRst,
    data_ram_arbiter_if.slave  bus
);

    localparam logic [30:0] WORD_LIMIT = 31'(DEPTH_WORDS);

    function automatic logic access_err(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = addr[0];
            3'b010:  bad = (addr[1:0] != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        return bad | ({1'b0, addr[31:2]} >= WORD_LIMIT);
    endfunction

    logic        prio_q, prio_d;          // 1: M1 wins the next conflict
    logic        s1_vld_q, s1_vld_d;
    logic        s1_own_q, s1_own_d;
    logic        s1_we_q, s1_we_d;
    logic [2:0]  s1_f3_q, s1_f3_d;
    logic [31:0] s1_addr_q, s1_addr_d;
    logic [31:0] s1_wdata_q, s1_wdata_d;
    logic        rsp0_q, rsp0_d, rsp1_q, rsp1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;

    logic        gnt0_s, gnt1_s;
    logic        s1_err_s, load_ok_s, ram_we_s;

    // Arbitration, stage-1 capture and response next-state.
    always_comb begin
        gnt0_s     = ~iRst & bus.iM0_Req & (~bus.iM1_Req | ~prio_q);
        gnt1_s     = ~iRst & bus.iM1_Req & (~bus.iM0_Req | prio_q);
        s1_vld_d   = gnt0_s | gnt1_s;
        prio_d     = prio_q;
        s1_own_d   = s1_own_q;
        s1_we_d    = s1_we_q;
        s1_f3_d    = s1_f3_q;
        s1_addr_d  = s1_addr_q;
        s1_wdata_d = s1_wdata_q;
        if (gnt1_s) begin
            prio_d     = 1'b0;
            s1_own_d   = 1'b1;
            s1_we_d    = bus.iM1_We;
            s1_f3_d    = bus.iM1_Funct3;
            s1_addr_d  = bus.iM1_Addr;
            s1_wdata_d = bus.iM1_WrData;
        end else if (gnt0_s) begin
            prio_d     = 1'b1;
            s1_own_d   = 1'b0;
            s1_we_d    = bus.iM0_We;
            s1_f3_d    = bus.iM0_Funct3;
            s1_addr_d  = bus.iM0_Addr;
            s1_wdata_d = bus.iM0_WrData;
        end else begin
            prio_d     = prio_q;
        end

        s1_err_s  = access_err(s1_we_q, s1_f3_q, s1_addr_q);
        ram_we_s  = s1_vld_q & s1_we_q & ~s1_err_s;
        load_ok_s = s1_vld_q & ~s1_we_q & ~s1_err_s;
        rsp0_d    = s1_vld_q & ~s1_own_q;
        rsp1_d    = s1_vld_q & s1_own_q;
        err0_d    = rsp0_d & s1_err_s;
        err1_d    = rsp1_d & s1_err_s;
        rd0_d     = (rsp0_d & load_ok_s) ? bus.iRam_RdData : 32'h0000_0000;
        rd1_d     = (rsp1_d & load_ok_s) ? bus.iRam_RdData : 32'h0000_0000;
    end

    // State registers; reset drops any in-flight access.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            prio_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_own_q   <= 1'b0;
            s1_we_q    <= 1'b0;
            s1_f3_q    <= 3'b000;
            s1_addr_q  <= 32'h0000_0000;
            s1_wdata_q <= 32'h0000_0000;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rd0_q      <= 32'h0000_0000;
            rd1_q      <= 32'h0000_0000;
        end else begin
            prio_q     <= prio_d;
            s1_vld_q   <= s1_vld_d;
            s1_own_q   <= s1_own_d;
            s1_we_q    <= s1_we_d;
            s1_f3_q    <= s1_f3_d;
            s1_addr_q  <= s1_addr_d;
            s1_wdata_q <= s1_wdata_d;
            rsp0_q     <= rsp0_d;
            rsp1_q     <= rsp1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
        end
    end

    assign bus.oM0_Gnt     = gnt0_s;
    assign bus.oM1_Gnt     = gnt1_s;
    assign bus.oM0_Rsp     = rsp0_q;
    assign bus.oM1_Rsp     = rsp1_q;
    assign bus.oM0_Err     = err0_q;
    assign bus.oM1_Err     = err1_q;
    assign bus.oM0_RdData  = rd0_q;
    assign bus.oM1_RdData  = rd1_q;
    // Address/data simply follow stage 1, so they hold their last value while idle.
    assign bus.oRam_WrEn   = ram_we_s;
    assign bus.oRam_Funct3 = s1_f3_q;
    assign bus.oRam_Addr   = s1_addr_q;
    assign bus.oRam_WrData = s1_wdata_q;

endmodule
